// File: rtl/vga_seq_pkg.sv
// Shared state encoding, register map and bypass pattern helper for the
// frame-synchronous video core sequencer.
package vga_seq_pkg;

   typedef enum logic [1:0] {MANUAL, ARM, AUTO} seq_state_t;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_BYPASS = 2'd1;
   localparam logic [1:0] REG_PERIOD = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int MAX_CORES = 8;

   // Core k generates while all others pass through. A step at or beyond the
   // core count shifts the single zero out of range, giving all ones.
   function automatic logic [MAX_CORES-1:0] step_pattern(input logic [3:0] k);
      logic [MAX_CORES-1:0] one;
      one = MAX_CORES'(1);
      step_pattern = ~(one << k);
   endfunction

endpackage

// File: rtl/vga_sof_detect.sv
// Start-of-frame pulse: one clk on the first cycle the frame counter sits at
// the origin, however many clks x/y are held there.
module vga_sof_detect (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] x,
   input  logic [10:0] y,
   output logic        sof
);

   logic origin;
   logic prev_origin_q;
   logic prev_origin_d;

   assign origin = (x == 11'd0) && (y == 11'd0);

   always_comb begin
      prev_origin_d = origin;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev_origin_q <= 1'b0;
      else       prev_origin_q <= prev_origin_d;
   end

   assign sof = origin && !prev_origin_q;

endmodule

// File: rtl/vga_core_sequencer.sv
// Register slot and frame-synchronous bypass sequencer for the video pipeline
// cores; every bypass change is deferred to start-of-frame.
module vga_core_sequencer
   import vga_seq_pkg::*;
#(
   parameter int N_CORES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [10:0]        x,
   input  logic [10:0]        y,
   input  logic               cs,
   input  logic               write,
   input  logic               read,
   input  logic [1:0]         addr,
   input  logic [31:0]        wr_data,
   output logic [31:0]        rd_data,
   output logic [N_CORES-1:0] bypass,
   output seq_state_t         dbg_state
);

   logic               sof;
   logic               wr_en;
   seq_state_t         state_q, state_d;
   logic               ctrl_q, ctrl_d;
   logic [N_CORES-1:0] bypass_reg_q, bypass_reg_d;
   logic [N_CORES-1:0] bypass_q, bypass_d;
   logic [15:0]        period_q, period_d;
   logic [15:0]        period_eff;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic [3:0]         step_q, step_d, step_nx;
   logic [31:0]        status;
   logic               unused_inputs;

   vga_sof_detect u_sof (
      .clk   (clk),
      .reset (reset),
      .x     (x),
      .y     (y),
      .sof   (sof)
   );

   // Reads are side-effect free, so the strobe only matters to the bus.
   assign unused_inputs = ^{read, wr_data[31:16]};

   assign wr_en      = cs & write;
   assign period_eff = (period_q == 16'd0) ? 16'd1 : period_q;
   assign step_nx    = (step_q == 4'(N_CORES)) ? 4'd0 : step_q + 4'd1;

   always_comb begin
      ctrl_d       = ctrl_q;
      bypass_reg_d = bypass_reg_q;
      period_d     = period_q;
      if (wr_en) begin
         case (addr)
            REG_CTRL:   ctrl_d       = wr_data[0];
            REG_BYPASS: bypass_reg_d = wr_data[N_CORES-1:0];
            REG_PERIOD: period_d     = wr_data[15:0];
            default:    ;
         endcase
      end
   end

   // The sof action always sees pre-write registers; a CTRL write then only
   // redirects the state, so its effect on bypass waits for the next sof.
   always_comb begin
      state_d     = state_q;
      bypass_d    = bypass_q;
      step_d      = step_q;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         MANUAL: begin
            if (sof) bypass_d = bypass_reg_q;
         end
         ARM: begin
            if (sof) begin
               step_d      = 4'd0;
               frame_cnt_d = 16'd0;
               bypass_d    = N_CORES'(step_pattern(4'd0));
               state_d     = AUTO;
            end
         end
         AUTO: begin
            if (sof) begin
               if (frame_cnt_q >= period_eff - 16'd1) begin
                  frame_cnt_d = 16'd0;
                  step_d      = step_nx;
                  bypass_d    = N_CORES'(step_pattern(step_nx));
               end else begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end
            end
         end
         default: state_d = MANUAL;
      endcase
      if (wr_en && addr == REG_CTRL) begin
         if (wr_data[0] && state_q == MANUAL)       state_d = ARM;
         else if (!wr_data[0] && state_q != MANUAL) state_d = MANUAL;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= MANUAL;
         ctrl_q       <= 1'b0;
         bypass_reg_q <= '1;
         bypass_q     <= '1;
         period_q     <= 16'd1;
         frame_cnt_q  <= 16'd0;
         step_q       <= 4'd0;
      end else begin
         state_q      <= state_d;
         ctrl_q       <= ctrl_d;
         bypass_reg_q <= bypass_reg_d;
         bypass_q     <= bypass_d;
         period_q     <= period_d;
         frame_cnt_q  <= frame_cnt_d;
         step_q       <= step_d;
      end
   end

   always_comb begin
      status                = '0;
      status[N_CORES-1:0]   = bypass_q;
      status[11:8]          = step_q;
      status[31:16]         = frame_cnt_q;
      rd_data               = '0;
      case (addr)
         REG_CTRL:   rd_data = {31'd0, ctrl_q};
         REG_BYPASS: rd_data = 32'(bypass_reg_q);
         REG_PERIOD: rd_data = {16'd0, period_q};
         default:    rd_data = status;
      endcase
   end

   assign bypass    = bypass_q;
   assign dbg_state = state_q;

endmodule

// File: doc/vga_core_sequencer.md
# vga_core_sequencer

Frame-synchronous controller for the video pipeline cores. It holds the bypass selection for up to N_CORES pipeline stages (bar generator, overlays, etc.) behind a memory-mapped register slot. Every bypass change is applied only at start-of-frame, so no frame ever shows a partial pattern switch. An auto mode steps through the cores, enabling one per step for a programmable number of frames, for unattended display test.

## Interface

- N_CORES, 4: number of pipeline cores controlled, 1..8
- clk  input  1  system clock (pixel tick is derived elsewhere; x/y hold for several clk cycles)
- reset  input  1  asynchronous, active-high
- x  input  11  global frame counter column
- y  input  11  global frame counter row
- cs  input  1  slot chip select
- write  input  1  write strobe, qualified by cs
- read  input  1  read strobe, qualified by cs (no side effects)
- addr  input  2  register index
- wr_data  input  32  write data
- rd_data  output  32  read data, combinational from addr
- bypass  output  N_CORES  per-core bypass; 1 = pass si_rgb through, 0 = core generates

## Operation

- Register map:
  - addr 0 CTRL: bit0 auto_en; other bits ignored.
  - addr 1 BYPASS: staged manual bypass, bits [N_CORES-1:0].
  - addr 2 PERIOD: frames per auto step, bits [15:0]; a value of 0 is treated as 1.
  - addr 3 STATUS (read-only): [N_CORES-1:0] live bypass, [11:8] step, [31:16] frame_cnt.
- Reads of addr 0–2 return the stored value, zero-extended.
- SOF detection: sof = (x==0 && y==0) && !prev_origin, where prev_origin is registered (x==0 && y==0). sof is exactly one clk per frame.
- State machine (shared enum):
  - MANUAL: on sof, bypass <= BYPASS. A CTRL write with auto_en=1 goes to ARM.
  - ARM: on sof, step <= 0, frame_cnt <= 0, bypass <= pattern(0), go to AUTO. A CTRL write with auto_en=0 goes to MANUAL.
  - AUTO: on sof, if frame_cnt >= PERIOD_eff-1, then frame_cnt <= 0, step <= (step==N_CORES) ? 0 : step+1, bypass <= pattern(next step). Otherwise frame_cnt++. A CTRL write with auto_en=0 goes to MANUAL; bypass is then updated from BYPASS at the next sof.
- pattern(k): for k<N_CORES, all ones with bit k cleared. pattern(N_CORES) is all ones (passthrough step).
- step width is 4 bits. frame_cnt width is 16 bits.
- Comparison uses >=, so a PERIOD reduced below the current frame_cnt advances the step on the next sof.

## Timing

- Reset values:
  - bypass = all ones
  - state = MANUAL
  - CTRL = 0
  - BYPASS = all ones
  - PERIOD = 1
  - step = 0
  - frame_cnt = 0
  - prev_origin = 0
- bypass is a register. It changes on the clk edge that ends the sof cycle and is visible the next cycle.
- Register writes land on the clk edge of the write cycle.
- Write coincident with sof: the sof update uses the pre-write register and state values. The written value takes effect at the following sof. Example: a CTRL auto_en=1 write during a sof cycle enters ARM and starts AUTO one frame later.
- A read is valid in the same cycle as cs & read.
- Reset asserted mid-frame: all state returns to reset values immediately. The first sof after reset release applies BYPASS = all ones, so bypass stays all ones.
- Before the first origin after reset, prev_origin=0. A reset released while x=y=0 therefore produces a sof on the first cycle.

## Structure

- Package vga_seq_pkg contains:
  - typedef enum logic [1:0] {MANUAL, ARM, AUTO} seq_state_t
  - localparams REG_CTRL=0, REG_BYPASS=1, REG_PERIOD=2, REG_STATUS=3
  - MAX_CORES=8
- Sub-module vga_sof_detect (clk, reset, x, y -> sof) holds the origin register and edge logic. Other frame-synchronous blocks reuse it.
- The top module contains the register file, the FSM, the step/frame counters and the read mux.

## Test plan

- Reset, then drive x/y for 3 frames: bypass = 4'b1111 throughout; STATUS reads 0x0000000F.
- Manual switch, write BYPASS=4'b1110 mid-frame:
  - bypass stays 4'b1111 until the next x=y=0 first cycle.
  - One clk later it reads 4'b1110.
  - It is unchanged while x=y=0 is held for 4 clk.
- Auto sequence, PERIOD=2 then CTRL=1:
  - After the next sof, bypass=1110.
  - Subsequent pairs of frames show 1101, 1011, 0111, 1111, then wrap to 1110.
  - STATUS step reads 0..4.
- Auto exit, CTRL=0 during AUTO with BYPASS=0000: bypass holds the current auto pattern until the next sof, then becomes 0000; state is MANUAL.
- Boundary cases:
  - PERIOD=0 behaves as 1, stepping every frame.
  - Writing PERIOD=1 when frame_cnt=5 advances the step at the next sof.
  - A CTRL=1 write coincident with sof produces no change at that sof; AUTO starts one frame later.
- Async reset asserted mid-AUTO: bypass becomes 1111 without a clock edge; CTRL reads 0; state is MANUAL.
